// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared state encoding, line levels and bit-timing helper
// rev 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  localparam logic c_STOP_LEVEL = 1'b1;
  localparam logic c_IDLE_LEVEL = 1'b1;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// sync_2ff : two-flop synchroniser with configurable reset value
// rev 1.0
// ============================================================================
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_meta;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_meta <= RST_VAL;
      q_o    <= RST_VAL;
    end else begin
      r_meta <= d_i;
      q_o    <= r_meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 8N1 receiver, mid-bit sampling, one-entry valid/ready output
// rev 1.0
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9_600,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int IW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] c_CPB_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] c_HALF_LAST = CW'(HALF - 1);
  localparam logic [IW-1:0] c_BIT_LAST  = IW'(DATA_BITS - 1);

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end
  endgenerate

  logic                 w_rx_s;
  logic                 r_rx_d;
  logic                 w_fall;
  state_t               r_state, w_state_n;
  logic [CW-1:0]        r_cnt, w_cnt_n;
  logic [IW-1:0]        r_idx, w_idx_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic                 w_commit;
  logic                 w_ferr;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (c_IDLE_LEVEL)
  ) u_sync (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    (rx_i),
    .q_o    (w_rx_s)
  );

  assign w_fall = r_rx_d && !w_rx_s;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_rx_d  <= c_IDLE_LEVEL;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_rx_d  <= w_rx_s;
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_commit  = 1'b0;
    w_ferr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_cnt_n   = '0;
          w_state_n = START;
        end
      end
      START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (r_cnt == c_HALF_LAST) begin
          if (w_rx_s) begin
            w_state_n = IDLE;
          end else begin
            w_cnt_n   = '0;
            w_idx_n   = '0;
            w_state_n = DATA;
          end
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      DATA: begin
        if (r_cnt == c_CPB_LAST) begin
          w_cnt_n          = '0;
          w_shift_n[r_idx] = w_rx_s;
          if (r_idx == c_BIT_LAST) w_state_n = STOP;
          else                     w_idx_n   = r_idx + IW'(1);
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      STOP: begin
        if (r_cnt == c_CPB_LAST) begin
          w_cnt_n = '0;
          if (w_rx_s == c_STOP_LEVEL) begin
            w_commit  = 1'b1;
            w_state_n = IDLE;
          end else begin
            w_ferr    = 1'b1;
            w_state_n = BRK;
          end
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      BRK: begin
        // Hold here for the whole break so it yields a single frame error.
        if (w_rx_s) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= w_ferr;
      overrun_o   <= w_commit && valid_o && !ready_i;
      if (w_commit && (!valid_o || ready_i)) begin
        data_o  <= r_shift;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_uart_rx : directed table-driven bench for uart_rx (CPB=16 and CPB=5208)
// rev 1.0
// ============================================================================
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst;
  logic       rx_a, rx_b, ready_a, ready_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, ferr_a, ferr_b, ovr_a, ovr_b;

  uart_rx #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_BITS(8)) dut_a (
    .clk_i(clk), .arst_i(arst), .rx_i(rx_a), .data_o(data_a), .valid_o(valid_a),
    .ready_i(ready_a), .frame_err_o(ferr_a), .overrun_o(ovr_a)
  );

  uart_rx #(.CLK_FREQ(50_000_000), .BAUD_RATE(9_600), .DATA_BITS(8)) dut_b (
    .clk_i(clk), .arst_i(arst), .rx_i(rx_b), .data_o(data_b), .valid_o(valid_b),
    .ready_i(ready_b), .frame_err_o(ferr_b), .overrun_o(ovr_b)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  rxq_a[$];
  logic [7:0]  rxq_b[$];
  int          ferr_cnt_a = 0, ovr_cnt_a = 0, ferr_cnt_b = 0, ovr_cnt_b = 0;
  int          rise_cnt_a = 0, both_cnt = 0, stab_err = 0;
  int unsigned rise_cyc_a = 0, fall_cyc_a = 0;
  logic        prev_valid_a = 1'b0, prev_hold_a = 1'b0;
  logic [7:0]  prev_data_a = 8'h00;

  always @(negedge clk) begin
    if (valid_a && !prev_valid_a) begin
      rise_cyc_a = cyc;
      rise_cnt_a++;
    end
    if (!valid_a && prev_valid_a) fall_cyc_a = cyc;
    if (valid_a && ready_a) rxq_a.push_back(data_a);
    if (valid_b && ready_b) rxq_b.push_back(data_b);
    if (ferr_a) ferr_cnt_a++;
    if (ovr_a)  ovr_cnt_a++;
    if (ferr_b) ferr_cnt_b++;
    if (ovr_b)  ovr_cnt_b++;
    if ((ferr_a && ovr_a) || (ferr_b && ovr_b)) both_cnt++;
    if (prev_hold_a && !arst && (data_a !== prev_data_a)) stab_err++;
    prev_hold_a  = valid_a && !ready_a;
    prev_data_a  = data_a;
    prev_valid_a = valid_a;
  end

  int pass_cnt = 0, total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] rx_at(input int idx);
    if (idx < rxq_a.size()) return rxq_a[idx];
    return 8'bx;
  endfunction

  int unsigned start_cyc = 0;

  // Drives start, data (LSB first) and stop bits; ready_a rises at tick index ready_at.
  task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop,
                            input int cpb, input int ready_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10 * cpb; i++) begin
      if (i == 0) start_cyc = cyc;
      if (sel) rx_b = bits[i / cpb];
      else     rx_a = bits[i / cpb];
      if (i == ready_at) ready_a = 1'b1;
      tick(1);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_byte;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];
  int   b0, f0, o0, r0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h55, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h0F, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b0};

    arst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    tick(2);
    check("reset_valid", {31'b0, valid_a}, 0);
    check("reset_data",  {24'b0, data_a}, 0);
    check("reset_errs",  {30'b0, ferr_a, ovr_a}, 0);
    arst = 1'b0;
    tick(5);

    // Latency: valid rises 155 cycles after rx_i falls (2 sync + 8 + 16*9 + 1).
    b0 = rxq_a.size(); f0 = ferr_cnt_a; o0 = ovr_cnt_a;
    send_frame(1'b0, 8'hA5, 1'b1, 16, -1);
    tick(10);
    check("t1_latency", rise_cyc_a - start_cyc, 155);
    check("t1_width",   fall_cyc_a - rise_cyc_a, 1);
    check("t1_count",   rxq_a.size() - b0, 1);
    check("t1_data",    {24'b0, rx_at(b0)}, 32'hA5);
    check("t1_errs",    (ferr_cnt_a - f0) + (ovr_cnt_a - o0), 0);

    for (int i = 0; i < 7; i++) begin
      b0 = rxq_a.size(); f0 = ferr_cnt_a; o0 = ovr_cnt_a;
      send_frame(1'b0, vecs[i].data, vecs[i].stop, 16, -1);
      rx_a = 1'b1;
      tick(20);
      check($sformatf("vec%0d_count", i), rxq_a.size() - b0, {31'b0, vecs[i].exp_byte});
      if (vecs[i].exp_byte)
        check($sformatf("vec%0d_data", i), {24'b0, rx_at(b0)}, {24'b0, vecs[i].data});
      check($sformatf("vec%0d_ferr", i), ferr_cnt_a - f0, {31'b0, vecs[i].exp_ferr});
      check($sformatf("vec%0d_ovr", i), ovr_cnt_a - o0, 0);
    end

    // Short low glitch must be rejected at the start-bit midpoint.
    b0 = rxq_a.size(); f0 = ferr_cnt_a;
    rx_a = 1'b0; tick(4); rx_a = 1'b1; tick(40);
    check("t2_glitch_count", rxq_a.size() - b0, 0);
    check("t2_glitch_ferr",  ferr_cnt_a - f0, 0);
    send_frame(1'b0, 8'h3C, 1'b1, 16, -1);
    tick(10);
    check("t2_next_data", {24'b0, rx_at(b0)}, 32'h3C);

    // Bad stop bit followed by a long break, then a good frame.
    b0 = rxq_a.size(); f0 = ferr_cnt_a; o0 = ovr_cnt_a;
    send_frame(1'b0, 8'h55, 1'b0, 16, -1);
    tick(100);
    rx_a = 1'b1;
    tick(20);
    send_frame(1'b0, 8'h0F, 1'b1, 16, -1);
    tick(10);
    check("t3_ferr",  ferr_cnt_a - f0, 1);
    check("t3_count", rxq_a.size() - b0, 1);
    check("t3_data",  {24'b0, rx_at(b0)}, 32'h0F);
    check("t3_ovr",   ovr_cnt_a - o0, 0);

    // Overrun: second byte dropped while the first is still pending.
    ready_a = 1'b0;
    b0 = rxq_a.size(); f0 = ferr_cnt_a; o0 = ovr_cnt_a;
    send_frame(1'b0, 8'h11, 1'b1, 16, -1);
    send_frame(1'b0, 8'h22, 1'b1, 16, -1);
    tick(10);
    check("t4_valid", {31'b0, valid_a}, 1);
    check("t4_data",  {24'b0, data_a}, 32'h11);
    check("t4_ovr",   ovr_cnt_a - o0, 1);
    check("t4_ferr",  ferr_cnt_a - f0, 0);
    ready_a = 1'b1;
    tick(2);
    check("t4_drain_valid", {31'b0, valid_a}, 0);
    check("t4_drain_count", rxq_a.size() - b0, 1);
    check("t4_drain_data",  {24'b0, rx_at(b0)}, 32'h11);

    // ready rises exactly on the commit cycle of the second byte.
    ready_a = 1'b0;
    send_frame(1'b0, 8'h11, 1'b1, 16, -1);
    tick(10);
    check("t5_pending", {31'b0, valid_a}, 1);
    b0 = rxq_a.size(); o0 = ovr_cnt_a; r0 = rise_cnt_a;
    send_frame(1'b0, 8'h22, 1'b1, 16, 154);
    tick(10);
    check("t5_count",  rxq_a.size() - b0, 2);
    check("t5_first",  {24'b0, rx_at(b0)}, 32'h11);
    check("t5_second", {24'b0, rx_at(b0 + 1)}, 32'h22);
    check("t5_ovr",    ovr_cnt_a - o0, 0);
    check("t5_no_gap", rise_cnt_a - r0, 0);
    check("t5_idle",   {31'b0, valid_a}, 0);

    // Asynchronous reset in the middle of a 0xFF frame.
    ready_a = 1'b1;
    b0 = rxq_a.size(); f0 = ferr_cnt_a;
    rx_a = 1'b0; tick(16);
    rx_a = 1'b1; tick(40);
    arst = 1'b1;
    #1;
    check("t6_rst_valid", {31'b0, valid_a}, 0);
    check("t6_rst_data",  {24'b0, data_a}, 0);
    check("t6_rst_errs",  {30'b0, ferr_a, ovr_a}, 0);
    tick(3);
    arst = 1'b0;
    tick(30);
    send_frame(1'b0, 8'h81, 1'b1, 16, -1);
    tick(10);
    check("t6_count", rxq_a.size() - b0, 1);
    check("t6_data",  {24'b0, rx_at(b0)}, 32'h81);
    check("t6_ferr",  ferr_cnt_a - f0, 0);

    // Real-rate smoke frame on the second instance.
    send_frame(1'b1, 8'h5A, 1'b1, 5208, -1);
    tick(20);
    check("smoke_count", rxq_b.size(), 1);
    check("smoke_data",  (rxq_b.size() > 0) ? {24'b0, rxq_b[0]} : 32'hxxxxxxxx, 32'h5A);
    check("smoke_errs",  ferr_cnt_b + ovr_cnt_b, 0);

    check("errs_exclusive", both_cnt, 0);
    check("data_stable",    stab_err, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
